// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage.
// Owns the fetch PC, issues sequential word requests to instruction memory
// over req/gnt/rvalid, and buffers returned words (tagged with their PC) in
// an in-order FIFO presented to decode over valid/ready. A redirect flushes
// the buffer and converts every in-flight kept request into a discard slot,
// so stale responses are dropped without ever stalling the memory port.
//
// Handshake semantics:
//   memory side : a request transfers in a cycle where imem_req_o && imem_gnt_i;
//                 once raised, imem_req_o/imem_addr_o hold until granted, except
//                 that redirect_i withdraws the request combinationally.
//                 Each grant yields exactly one in-order imem_rvalid_i later.
//   decode side : an entry transfers in a cycle where if_id_valid_o && if_id_ready_i;
//                 if_id_* are driven from registers only and hold while not taken.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_id_valid_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_instr_o,
    input  logic        if_id_ready_i
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW = CW + 2;
    localparam logic [31:0]   NOP_INSTR = 32'h0000_0013;
    localparam logic [SW-1:0] DEPTH_S   = SW'(FIFO_DEPTH);

    // Architectural state
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    // Buffer storage (no reset: contents are qualified by count_q)
    logic [31:0] mem_pc_q    [FIFO_DEPTH];
    logic [31:0] mem_instr_q [FIFO_DEPTH];

    // Handshake decodes
    logic          grant;
    logic          push;
    logic          drop;
    logic          pop;
    logic [SW-1:0] credit_sum;
    logic [31:0]   redirect_target;

    // The two low redirect bits are deliberately ignored.
    logic unused_redirect_low;
    assign unused_redirect_low = ^redirect_pc_i[1:0];

    assign redirect_target = {redirect_pc_i[31:2], 2'b00};

    // Every word granted but not yet returned, plus every word buffered, holds
    // a credit; the pop in this cycle is not counted so that ready never
    // reaches the request path.
    assign credit_sum = SW'(outstanding_q) + SW'(discard_q) + SW'(count_q);

    // Request is withdrawn while in reset and in a redirect cycle.
    assign imem_req_o  = rst_ni && !redirect_i && (credit_sum < DEPTH_S);
    assign imem_addr_o = fetch_pc_q;

    assign grant = imem_req_o && imem_gnt_i;
    // A response is kept only when no squashed request is ahead of it and the
    // stage is not being redirected in the same cycle.
    assign push  = imem_rvalid_i && (discard_q == '0) && !redirect_i;
    assign drop  = imem_rvalid_i && (discard_q != '0);
    assign pop   = if_id_valid_o && if_id_ready_i;

    // Decode-facing outputs come straight from registers.
    assign if_id_valid_o = (count_q != '0);
    assign if_id_pc_o    = if_id_valid_o ? mem_pc_q[rd_ptr_q]    : 32'h0;
    assign if_id_instr_o = if_id_valid_o ? mem_instr_q[rd_ptr_q] : NOP_INSTR;

    // Next-state computation; a redirect overrides every other update.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        if (redirect_i) begin
            fetch_pc_d    = redirect_target;
            resp_pc_d     = redirect_target;
            outstanding_d = '0;
            // All kept requests become squashed; a response arriving now is
            // dropped and retires one slot (a discard slot if any, else one of
            // the just-converted kept requests).
            discard_d     = discard_q + outstanding_q - CW'(imem_rvalid_i);
            count_d       = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wr_ptr_d  = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            outstanding_d = outstanding_q + CW'(grant) - CW'(push);
            discard_d     = discard_q - CW'(drop);
            count_d       = count_q + CW'(push) - CW'(pop);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q    <= RESET_VECTOR;
            resp_pc_q     <= RESET_VECTOR;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Buffer write: each kept response is stored with the PC it answers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]    <= resp_pc_q;
            mem_instr_q[wr_ptr_q] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Testbench for instr_fetch_stage: directed scenarios followed by a random
// phase, all checked every cycle against a transaction-level model of the
// memory and the decode-visible instruction stream.
module tb_instr_fetch_stage;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h8000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mem_ent_t;

    // ---------------- clock / reset / DUT ----------------
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        if_id_valid_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_instr_o;
    logic        if_id_ready_i;

    always #5 clk_i = ~clk_i;

    instr_fetch_stage #(
        .RESET_VECTOR(RV),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .if_id_valid_o(if_id_valid_o),
        .if_id_pc_o   (if_id_pc_o),
        .if_id_instr_o(if_id_instr_o),
        .if_id_ready_i(if_id_ready_i)
    );

    // ---------------- model state ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          since_rst = 0;
    int          gnt_mode = 0;     // 0 always grant, 1 random, 2 never
    int          lat_fix  = 1;     // 0 means random latency 1..3
    bit          rand_ready = 1'b0;
    int          epoch = 0;
    logic [31:0] exp_fetch = RV;
    logic        prev_req = 1'b0;
    logic        prev_gnt = 1'b0;
    logic [31:0] prev_addr = '0;
    int          first_valid_rel = -1;
    int          redir_cyc = 0;
    int          redir_lat = -1;
    int          pop_count = 0;

    mem_ent_t    mem_q[$];          // granted, not yet returned
    logic [63:0] exp_q[$];          // {pc, instr} expected at decode, in order
    logic [31:0] popped_pc[$];
    logic [31:0] popped_instr[$];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic int cur_count();
        int n = 0;
        foreach (mem_q[i]) if (mem_q[i].epoch == epoch) n++;
        return n;
    endfunction

    function automatic int stale_count();
        int n = 0;
        foreach (mem_q[i]) if (mem_q[i].epoch != epoch) n++;
        return n;
    endfunction

    function automatic logic [31:0] popped_at(input int i);
        if (i < popped_pc.size()) return popped_pc[i];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] popped_instr_at(input int i);
        if (i < popped_instr.size()) return popped_instr[i];
        return 32'hxxxx_xxxx;
    endfunction

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Memory and decode inputs for the cycle starting at this negedge.
    task automatic drive_mem();
        case (gnt_mode)
            0:       imem_gnt_i = 1'b1;
            1:       imem_gnt_i = ($urandom_range(0, 3) != 0);
            default: imem_gnt_i = 1'b0;
        endcase
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_data(mem_q[0].addr);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom();
        end
        if (rand_ready) if_id_ready_i = 1'($urandom_range(0, 1));
        redirect_i = 1'b0;
    endtask

    // Check settled outputs, advance the model by one clock, redrive inputs.
    task automatic cycle();
        logic        exp_valid;
        logic        exp_req;
        logic        g;
        logic        p;
        logic [63:0] head;
        mem_ent_t    e;
        int          lat;
        #1;
        exp_valid = (exp_q.size() != 0);
        head = exp_valid ? exp_q[0] : {32'h0, NOP};
        check("valid", 32'(if_id_valid_o), 32'(exp_valid));
        check("pc", if_id_pc_o, head[63:32]);
        check("instr", if_id_instr_o, head[31:0]);
        exp_req = !redirect_i && ((mem_q.size() + exp_q.size()) < DEPTH);
        check("req", 32'(imem_req_o), 32'(exp_req));
        check("addr", imem_addr_o, exp_fetch);
        if (prev_req && !prev_gnt && !redirect_i) begin
            check("req_hold", 32'(imem_req_o), 32'd1);
            check("addr_hold", imem_addr_o, prev_addr);
        end
        check("inv_count", 32'(int'(dut.count_q) <= DEPTH), 32'd1);
        check("inv_credit", 32'((int'(dut.outstanding_q) + int'(dut.discard_q)
                                + int'(dut.count_q)) <= DEPTH), 32'd1);

        if (if_id_valid_o && first_valid_rel < 0) first_valid_rel = since_rst;
        if (if_id_valid_o && redir_lat < 0) redir_lat = cyc - redir_cyc;
        g = imem_req_o && imem_gnt_i;
        p = if_id_valid_o && if_id_ready_i;
        if (p) begin
            popped_pc.push_back(if_id_pc_o);
            popped_instr.push_back(if_id_instr_o);
            pop_count++;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (imem_rvalid_i && mem_q.size() != 0) begin
            e = mem_q.pop_front();
            if (!redirect_i && e.epoch == epoch) exp_q.push_back({e.addr, mem_data(e.addr)});
        end
        if (g) begin
            lat = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 3));
            mem_q.push_back('{imem_addr_o, epoch, cyc + lat});
            exp_fetch = exp_fetch + 32'd4;
        end
        if (redirect_i) begin
            exp_q.delete();
            epoch++;
            exp_fetch = {redirect_pc_i[31:2], 2'b00};
            redir_cyc = cyc;
            redir_lat = -1;
        end
        prev_req  = imem_req_o;
        prev_gnt  = imem_gnt_i;
        prev_addr = imem_addr_o;
        @(posedge clk_i);
        cyc++;
        since_rst++;
        @(negedge clk_i);
        drive_mem();
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_pc_i = target;
        redirect_i    = 1'b1;
        cycle();
    endtask

    // Asynchronous reset pulse placed mid-cycle.
    task automatic async_reset(input int hold);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_req", 32'(imem_req_o), 32'd0);
        check("arst_addr", imem_addr_o, RV);
        check("arst_valid", 32'(if_id_valid_o), 32'd0);
        check("arst_pc", if_id_pc_o, 32'h0);
        check("arst_instr", if_id_instr_o, NOP);
        mem_q.delete();
        exp_q.delete();
        epoch++;
        exp_fetch = RV;
        prev_req = 1'b0;
        prev_gnt = 1'b0;
        redirect_i = 1'b0;
        imem_rvalid_i = 1'b0;
        repeat (hold) @(negedge clk_i);
        rst_ni = 1'b1;
        since_rst = 0;
        first_valid_rel = -1;
        pop_count = 0;
        drive_mem();
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic        found;
        logic [31:0] saved_addr;
        int          exp_disc;

        redirect_i = 1'b0;
        redirect_pc_i = '0;
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i = '0;
        if_id_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_addr", imem_addr_o, RV);
        check("rst_valid", 32'(if_id_valid_o), 32'd0);
        check("rst_pc", if_id_pc_o, 32'h0);
        check("rst_instr", if_id_instr_o, NOP);

        // Streaming after reset: 1-cycle memory, decode always ready.
        rst_ni = 1'b1;
        since_rst = 0;
        gnt_mode = 0;
        lat_fix = 1;
        if_id_ready_i = 1'b1;
        drive_mem();
        repeat (30) cycle();
        check("p1_first_valid", 32'(first_valid_rel), 32'd2);
        check("p1_throughput", 32'(pop_count), 32'd28);
        check("p1_pc0", popped_at(0), 32'h8000_0000);
        check("p1_pc1", popped_at(1), 32'h8000_0004);
        check("p1_instr1", popped_instr_at(1), 32'h8000_0004 ^ 32'hA5A5_0000);

        // Decode stall: buffer fills and requests stop.
        if_id_ready_i = 1'b0;
        do_redirect(RV);
        repeat (10) cycle();
        #1;
        check("p2_req_drop", 32'(imem_req_o), 32'd0);
        check("p2_head_pc", if_id_pc_o, RV);
        popped_pc.delete();
        popped_instr.delete();
        if_id_ready_i = 1'b1;
        repeat (8) cycle();
        for (int i = 0; i < 4; i++) begin
            check("p2_drain_pc", popped_at(i), RV + 32'(4 * i));
        end

        // Redirect with kept requests in flight and entries buffered.
        lat_fix = 2;
        if_id_ready_i = 1'b0;
        do_redirect(32'h9000_0000);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (cur_count() == 2 && exp_q.size() == 2) found = 1'b1;
            else cycle();
        end
        check("p3_setup", 32'(found), 32'd1);
        do_redirect(32'h8000_0103);
        #1;
        check("p3_valid_drop", 32'(if_id_valid_o), 32'd0);
        popped_pc.delete();
        popped_instr.delete();
        if_id_ready_i = 1'b1;
        for (int i = 0; i < 20 && popped_pc.size() == 0; i++) cycle();
        check("p3_first_pc", popped_at(0), 32'h8000_0100);
        check("p3_first_instr", popped_instr_at(0), mem_data(32'h8000_0100));

        // Redirect coinciding with the response that retires the last discard.
        lat_fix = 3;
        do_redirect(32'hA000_0000);
        found = 1'b0;
        exp_disc = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (stale_count() == 1 && imem_rvalid_i && mem_q.size() != 0
                && mem_q[0].epoch != epoch) begin
                found = 1'b1;
            end else if (stale_count() == 0) begin
                do_redirect(32'hA000_0000 + 32'(i * 256));
            end else begin
                cycle();
            end
        end
        check("p4_setup", 32'(found), 32'd1);
        exp_disc = cur_count();
        do_redirect(32'hA000_1000);
        #1;
        check("p4_discard", 32'(dut.discard_q), 32'(exp_disc));
        repeat (20) cycle();

        // Grant withheld: request and address hold, redirect retargets.
        gnt_mode = 2;
        repeat (6) cycle();
        #1;
        saved_addr = imem_addr_o;
        check("p5_req_pending", 32'(imem_req_o), 32'd1);
        repeat (5) cycle();
        #1;
        check("p5_req_hold", 32'(imem_req_o), 32'd1);
        check("p5_addr_hold", imem_addr_o, saved_addr);
        do_redirect(32'hB000_0041);
        #1;
        check("p5_addr_redirect", imem_addr_o, 32'hB000_0040);
        check("p5_req_after", 32'(imem_req_o), 32'd1);
        gnt_mode = 0;
        repeat (10) cycle();

        // Asynchronous reset mid-stream with requests in flight.
        lat_fix = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (cur_count() == 2) found = 1'b1;
            else cycle();
        end
        check("p6_setup", 32'(found), 32'd1);
        async_reset(2);
        #1;
        check("p6_restart_addr", imem_addr_o, RV);
        check("p6_restart_req", 32'(imem_req_o), 32'd1);
        repeat (12) cycle();

        // Address wrap at the top of the address space.
        lat_fix = 1;
        repeat (5) cycle();
        do_redirect(32'hFFFF_FFF8);
        popped_pc.delete();
        popped_instr.delete();
        repeat (10) cycle();
        check("p7_pc0", popped_at(0), 32'hFFFF_FFF8);
        check("p7_pc1", popped_at(1), 32'hFFFF_FFFC);
        check("p7_pc2", popped_at(2), 32'h0000_0000);
        check("p7_instr2", popped_instr_at(2), 32'hA5A5_0000);
        check("p7_redirect_latency", 32'(redir_lat), 32'd3);

        // Random traffic: grants, latency, decode stalls and redirects.
        gnt_mode = 1;
        lat_fix = 0;
        rand_ready = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                redirect_pc_i = $urandom();
                redirect_i = 1'b1;
            end
            cycle();
        end
        rand_ready = 1'b0;
        if_id_ready_i = 1'b1;
        gnt_mode = 0;
        repeat (20) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
